// File: rtl/img_region_rect_pkg.sv
// Shared types for the rectangular region flag stage: coordinate types, the
// rectangle parameter set, its power-on value and the inclusive containment test.
package img_region_rect_pkg;

    localparam int RECT_X_BITS = 11;
    localparam int RECT_Y_BITS = 10;

    typedef logic [RECT_X_BITS-1:0] x_t;
    typedef logic [RECT_Y_BITS-1:0] y_t;

    typedef struct packed {
        logic enable;
        x_t   left;
        x_t   right;
        y_t   top;
        y_t   bottom;
    } rect_param_t;

    // Full-frame rectangle, enabled: every pixel is flagged until reprogrammed.
    localparam rect_param_t INIT_RECT = '{
        enable: 1'b1,
        left:   '0,
        right:  '1,
        top:    '0,
        bottom: '1
    };

    // Inclusive, unsigned bounds; an inverted range yields an empty region.
    function automatic logic rect_contains(input rect_param_t p, input x_t x, input y_t y);
        return p.enable
            && (x >= p.left) && (x <= p.right)
            && (y >= p.top)  && (y <= p.bottom);
    endfunction

endpackage

// File: rtl/img_region_rect_param_shadow.sv
// Double-buffered rectangle parameters: requests are held until a frame start,
// where the candidate set is loaded and also used for that very pixel.
module img_region_rect_param_shadow
    import img_region_rect_pkg::*;
#(
    parameter rect_param_t INIT_PARAM = INIT_RECT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_start,
    input  logic        update_req,
    input  rect_param_t param_in,
    output rect_param_t sel_param,
    output rect_param_t active_param,
    output logic        update_index
);

    logic        pending_q;
    logic        pending_d;
    rect_param_t active_q;
    rect_param_t active_d;
    logic        index_q;
    logic        index_d;
    logic        apply;

    assign apply = frame_start & (pending_q | update_req);

    always_comb begin
        pending_d = pending_q;
        active_d  = active_q;
        index_d   = index_q;
        if (apply) begin
            pending_d = 1'b0;
            active_d  = param_in;
            index_d   = ~index_q;
        end else if (update_req) begin
            // Latched even while the pipeline is stalled.
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= 1'b0;
            active_q  <= INIT_PARAM;
            index_q   <= 1'b0;
        end else begin
            pending_q <= pending_d;
            active_q  <= active_d;
            index_q   <= index_d;
        end
    end

    // Bypass the register on the frame-start pixel so no bubble is needed.
    assign sel_param    = apply ? param_in : active_q;
    assign active_param = active_q;
    assign update_index = index_q;

endmodule

// File: rtl/img_region_rect_flag.sv
// Pixel-stream stage tagging pixels inside a programmable inclusive rectangle;
// data and framing pass through with one cycle of latency.
module img_region_rect_flag
    import img_region_rect_pkg::*;
#(
    parameter int                X_BITS      = RECT_X_BITS,
    parameter int                Y_BITS      = RECT_Y_BITS,
    parameter int                DATA_BITS   = 24,
    parameter bit                BYPASS_SIZE = 1'b1,
    parameter bit                INIT_ENABLE = 1'b1,
    parameter logic [X_BITS-1:0] INIT_LEFT   = '0,
    parameter logic [X_BITS-1:0] INIT_RIGHT  = '1,
    parameter logic [Y_BITS-1:0] INIT_TOP    = '0,
    parameter logic [Y_BITS-1:0] INIT_BOTTOM = '1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cke,

    input  logic                 update_req,
    input  logic                 param_enable,
    input  logic [X_BITS-1:0]    param_left,
    input  logic [X_BITS-1:0]    param_right,
    input  logic [Y_BITS-1:0]    param_top,
    input  logic [Y_BITS-1:0]    param_bottom,
    output logic                 update_index,
    output logic                 active_enable,

    input  logic [Y_BITS-1:0]    s_rows,
    input  logic [X_BITS-1:0]    s_cols,
    input  logic                 s_row_first,
    input  logic                 s_row_last,
    input  logic                 s_col_first,
    input  logic                 s_col_last,
    input  logic                 s_de,
    input  logic [DATA_BITS-1:0] s_data,
    input  logic                 s_valid,

    output logic [Y_BITS-1:0]    m_rows,
    output logic [X_BITS-1:0]    m_cols,
    output logic                 m_row_first,
    output logic                 m_row_last,
    output logic                 m_col_first,
    output logic                 m_col_last,
    output logic                 m_de,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_region,
    output logic                 m_valid
);

    localparam rect_param_t INIT_PARAM = '{
        enable: INIT_ENABLE,
        left:   INIT_LEFT,
        right:  INIT_RIGHT,
        top:    INIT_TOP,
        bottom: INIT_BOTTOM
    };

    logic        frame_start;
    logic        pix_en;
    rect_param_t param_in;
    rect_param_t sel_param;
    rect_param_t active_param;

    assign frame_start = cke & s_valid & s_row_first & s_col_first;
    assign pix_en      = cke & s_valid;

    assign param_in = '{
        enable: param_enable,
        left:   param_left,
        right:  param_right,
        top:    param_top,
        bottom: param_bottom
    };

    img_region_rect_param_shadow #(
        .INIT_PARAM (INIT_PARAM)
    ) u_shadow (
        .clk          (clk),
        .reset        (reset),
        .frame_start  (frame_start),
        .update_req   (update_req),
        .param_in     (param_in),
        .sel_param    (sel_param),
        .active_param (active_param),
        .update_index (update_index)
    );

    assign active_enable = active_param.enable;

    // ------------------------------------------------------------------
    // Coordinate tracking
    // ------------------------------------------------------------------
    x_t   x_q;
    x_t   x_d;
    y_t   y_q;
    y_t   y_d;
    x_t   x_cur;
    y_t   y_cur;
    logic region;

    always_comb begin
        x_cur = s_col_first ? '0 : x_q + 1'b1;
        if (s_row_first & s_col_first) begin
            y_cur = '0;
        end else if (s_col_first) begin
            y_cur = y_q + 1'b1;
        end else begin
            y_cur = y_q;
        end
    end

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (pix_en) begin
            x_d = x_cur;
            y_d = y_cur;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign region = rect_contains(sel_param, x_cur, y_cur);

    // ------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------
    logic                 row_first_q, row_first_d;
    logic                 row_last_q,  row_last_d;
    logic                 col_first_q, col_first_d;
    logic                 col_last_q,  col_last_d;
    logic                 de_q,        de_d;
    logic                 valid_q,     valid_d;
    logic                 region_q,    region_d;
    logic [DATA_BITS-1:0] data_q,      data_d;

    always_comb begin
        row_first_d = row_first_q;
        row_last_d  = row_last_q;
        col_first_d = col_first_q;
        col_last_d  = col_last_q;
        de_d        = de_q;
        valid_d     = valid_q;
        region_d    = region_q;
        data_d      = data_q;
        if (cke) begin
            row_first_d = s_row_first;
            row_last_d  = s_row_last;
            col_first_d = s_col_first;
            col_last_d  = s_col_last;
            de_d        = s_de;
            valid_d     = s_valid;
            region_d    = region & s_valid;
            data_d      = s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row_first_q <= 1'b0;
            row_last_q  <= 1'b0;
            col_first_q <= 1'b0;
            col_last_q  <= 1'b0;
            de_q        <= 1'b0;
            valid_q     <= 1'b0;
            region_q    <= 1'b0;
            data_q      <= '0;
        end else begin
            row_first_q <= row_first_d;
            row_last_q  <= row_last_d;
            col_first_q <= col_first_d;
            col_last_q  <= col_last_d;
            de_q        <= de_d;
            valid_q     <= valid_d;
            region_q    <= region_d;
            data_q      <= data_d;
        end
    end

    assign m_row_first = row_first_q;
    assign m_row_last  = row_last_q;
    assign m_col_first = col_first_q;
    assign m_col_last  = col_last_q;
    assign m_de        = de_q;
    assign m_valid     = valid_q;
    assign m_region    = region_q;
    assign m_data      = data_q;

    generate
        if (BYPASS_SIZE) begin : g_size
            logic [Y_BITS-1:0] rows_q, rows_d;
            logic [X_BITS-1:0] cols_q, cols_d;

            always_comb begin
                rows_d = rows_q;
                cols_d = cols_q;
                if (cke) begin
                    rows_d = s_rows;
                    cols_d = s_cols;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    rows_q <= '0;
                    cols_q <= '0;
                end else begin
                    rows_q <= rows_d;
                    cols_q <= cols_d;
                end
            end

            assign m_rows = rows_q;
            assign m_cols = cols_q;
        end else begin : g_no_size
            logic unused_size;
            assign unused_size = ^{s_rows, s_cols};
            assign m_rows = '0;
            assign m_cols = '0;
        end
    endgenerate

endmodule

// File: tb/tb_img_region_rect_flag.sv
// Directed bench for img_region_rect_flag on an 8x4 frame; per-pixel expectations
// come from the hand-specified rectangle of each scenario.
module tb_img_region_rect_flag;

    localparam int XB = 11;
    localparam int YB = 10;
    localparam int DB = 24;
    localparam int W  = 8;
    localparam int H  = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          cke;
    logic          update_req;
    logic          param_enable;
    logic [XB-1:0] param_left, param_right;
    logic [YB-1:0] param_top, param_bottom;
    logic          update_index;
    logic          active_enable;
    logic [YB-1:0] s_rows, m_rows;
    logic [XB-1:0] s_cols, m_cols;
    logic          s_row_first, s_row_last, s_col_first, s_col_last, s_de, s_valid;
    logic [DB-1:0] s_data, m_data;
    logic          m_row_first, m_row_last, m_col_first, m_col_last, m_de, m_valid;
    logic          m_region;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    img_region_rect_flag dut (
        .clk           (clk),
        .reset         (reset),
        .cke           (cke),
        .update_req    (update_req),
        .param_enable  (param_enable),
        .param_left    (param_left),
        .param_right   (param_right),
        .param_top     (param_top),
        .param_bottom  (param_bottom),
        .update_index  (update_index),
        .active_enable (active_enable),
        .s_rows        (s_rows),
        .s_cols        (s_cols),
        .s_row_first   (s_row_first),
        .s_row_last    (s_row_last),
        .s_col_first   (s_col_first),
        .s_col_last    (s_col_last),
        .s_de          (s_de),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .m_rows        (m_rows),
        .m_cols        (m_cols),
        .m_row_first   (m_row_first),
        .m_row_last    (m_row_last),
        .m_col_first   (m_col_first),
        .m_col_last    (m_col_last),
        .m_de          (m_de),
        .m_data        (m_data),
        .m_region      (m_region),
        .m_valid       (m_valid)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic logic in_rect(input int x, input int y, input logic en,
                                     input int l, input int r, input int t, input int b);
        return en && (x >= l) && (x <= r) && (y >= t) && (y <= b);
    endfunction

    // 1: cke stall before the pixel, 2: invalid cycle before it, 3: stall with update_req
    function automatic int gap_of(input int idx);
        if (idx == 13)    return 3;
        if (idx % 5 == 2) return 1;
        if (idx % 7 == 3) return 2;
        return 0;
    endfunction

    task automatic set_params(input logic en, input int l, input int r, input int t, input int b);
        param_enable = en;
        param_left   = XB'(l);
        param_right  = XB'(r);
        param_top    = YB'(t);
        param_bottom = YB'(b);
    endtask

    task automatic set_pixel_fields(input int x, input int y);
        s_valid     = 1'b1;
        s_de        = 1'b1;
        s_row_first = (y == 0);
        s_row_last  = (y == H - 1);
        s_col_first = (x == 0);
        s_col_last  = (x == W - 1);
        s_data      = {8'(y), 8'(x), 8'hA5};
    endtask

    task automatic idle_cycle(input logic req);
        cke         = 1'b1;
        s_valid     = 1'b0;
        s_de        = 1'b0;
        s_row_first = 1'b0;
        s_row_last  = 1'b0;
        s_col_first = 1'b0;
        s_col_last  = 1'b0;
        s_data      = DB'($urandom);
        update_req  = req;
        @(posedge clk);
        #1;
        update_req  = 1'b0;
    endtask

    task automatic send_pixel(input int x, input int y, input logic req, input int gap,
                              input logic en, input int l, input int r, input int t, input int b,
                              output logic got_region);
        logic [DB-1:0] d;
        logic          exp_r;
        logic [50:0]   exp_v;
        logic [50:0]   act_v;
        logic [DB+2:0] saved;
        logic [DB+2:0] now_v;
        if (gap == 1 || gap == 3) begin
            saved = {m_valid, m_region, update_index, m_data};
            cke = 1'b0;
            set_pixel_fields(x, y);
            update_req = (gap == 3);
            @(posedge clk);
            #1;
            update_req = 1'b0;
            now_v = {m_valid, m_region, update_index, m_data};
            checks++;
            if (now_v !== saved) begin
                errors++;
                $display("FAIL stall_hold (%0d,%0d) got %h want %h", x, y, now_v, saved);
            end
        end else if (gap == 2) begin
            idle_cycle(1'b0);
            checks++;
            if ({m_valid, m_region} !== 2'b00) begin
                errors++;
                $display("FAIL invalid_gap (%0d,%0d) got valid=%b region=%b want 0 0",
                         x, y, m_valid, m_region);
            end
        end
        cke = 1'b1;
        set_pixel_fields(x, y);
        d = s_data;
        update_req = req;
        @(posedge clk);
        #1;
        update_req = 1'b0;
        exp_r = in_rect(x, y, en, l, r, t, b);
        checks++;
        if (m_region !== exp_r) begin
            errors++;
            $display("FAIL region (%0d,%0d) got %b want %b", x, y, m_region, exp_r);
        end
        exp_v = {1'b1, (y == 0), (y == H - 1), (x == 0), (x == W - 1), 1'b1, d,
                 YB'(H), XB'(W)};
        act_v = {m_valid, m_row_first, m_row_last, m_col_first, m_col_last, m_de, m_data,
                 m_rows, m_cols};
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL passthru (%0d,%0d) got %h want %h", x, y, act_v, exp_v);
        end
        $display("pixel (%0d,%0d) region=%b idx=%b", x, y, m_region, update_index);
        got_region = m_region;
    endtask

    task automatic run_frame(input string name, input int req_idx, input bit gaps,
                             input logic en, input int l, input int r, input int t, input int b,
                             input int exp_count);
        int   count;
        logic g;
        count = 0;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                send_pixel(x, y, (y * W + x) == req_idx, gaps ? gap_of(y * W + x) : 0,
                           en, l, r, t, b, g);
                if (g === 1'b1) count++;
            end
        end
        idle_cycle(1'b0);
        checks++;
        if (count != exp_count) begin
            errors++;
            $display("FAIL %s_count got %0d want %0d", name, count, exp_count);
        end
    endtask

    task automatic check_index(input string name, input logic exp_idx);
        checks++;
        if (update_index !== exp_idx) begin
            errors++;
            $display("FAIL %s_update_index got %b want %b", name, update_index, exp_idx);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) idle_cycle(1'b0);
        checks++;
        if ({m_valid, m_region, m_de, m_data, m_rows, m_cols} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got valid=%b region=%b data=%h want zeros",
                     m_valid, m_region, m_data);
        end
        check_index("reset", 1'b0);
        checks++;
        if (active_enable !== 1'b1) begin
            errors++;
            $display("FAIL reset_active_enable got %b want 1", active_enable);
        end
        reset = 1'b0;
        idle_cycle(1'b0);
    endtask

    task automatic test_basic();
        set_params(1'b1, 2, 5, 1, 2);
        idle_cycle(1'b1);
        check_index("basic_pending", 1'b0);
        run_frame("basic", -1, 1'b0, 1'b1, 2, 5, 1, 2, 8);
        check_index("basic", 1'b1);
    endtask

    task automatic test_mid_frame();
        set_params(1'b1, 2, 3, 1, 2);
        run_frame("mid_old", 10, 1'b0, 1'b1, 2, 5, 1, 2, 8);
        check_index("mid_old", 1'b1);
        run_frame("mid_new", -1, 1'b0, 1'b1, 2, 3, 1, 2, 4);
        check_index("mid_new", 1'b0);
    endtask

    task automatic test_same_cycle();
        set_params(1'b1, 0, 7, 0, 0);
        run_frame("same", 0, 1'b0, 1'b1, 0, 7, 0, 0, 8);
        check_index("same", 1'b1);
        // Candidates change without a request: nothing may be pending.
        set_params(1'b0, 4, 4, 3, 3);
        run_frame("same_hold", -1, 1'b0, 1'b1, 0, 7, 0, 0, 8);
        check_index("same_hold", 1'b1);
    endtask

    task automatic test_empty();
        set_params(1'b0, 0, 7, 0, 3);
        run_frame("disabled", 0, 1'b0, 1'b0, 0, 7, 0, 3, 0);
        check_index("disabled", 1'b0);
        checks++;
        if (active_enable !== 1'b0) begin
            errors++;
            $display("FAIL disabled_active_enable got %b want 0", active_enable);
        end
        set_params(1'b1, 6, 1, 0, 3);
        run_frame("inverted", 0, 1'b0, 1'b1, 6, 1, 0, 3, 0);
        check_index("inverted", 1'b1);
    endtask

    task automatic test_gaps();
        set_params(1'b1, 2, 5, 1, 2);
        run_frame("gaps", 0, 1'b1, 1'b1, 2, 5, 1, 2, 8);
        check_index("gaps", 1'b0);
        // A request was raised during a stall in the gapped frame.
        set_params(1'b1, 2, 4, 1, 2);
        run_frame("stall_req", -1, 1'b0, 1'b1, 2, 4, 1, 2, 6);
        check_index("stall_req", 1'b1);
    endtask

    task automatic test_reset_mid_frame();
        logic g;
        for (int i = 0; i < 11; i++) begin
            send_pixel(i % W, i / W, 1'b0, 0, 1'b1, 2, 4, 1, 2, g);
        end
        cke = 1'b1;
        set_pixel_fields(3, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if ({m_valid, m_region} !== 2'b00) begin
            errors++;
            $display("FAIL rst_mid_outputs got valid=%b region=%b want 0 0", m_valid, m_region);
        end
        check_index("rst_mid", 1'b0);
        checks++;
        if (active_enable !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_active_enable got %b want 1", active_enable);
        end
        idle_cycle(1'b0);
        run_frame("rst_full", -1, 1'b0, 1'b1, 0, 2047, 0, 1023, 32);
        check_index("rst_full", 1'b0);
    endtask

    initial begin
        reset       = 1'b1;
        cke         = 1'b1;
        update_req  = 1'b0;
        s_rows      = YB'(H);
        s_cols      = XB'(W);
        s_valid     = 1'b0;
        s_de        = 1'b0;
        s_row_first = 1'b0;
        s_row_last  = 1'b0;
        s_col_first = 1'b0;
        s_col_last  = 1'b0;
        s_data      = '0;
        set_params(1'b0, 0, 0, 0, 0);

        test_reset();
        test_basic();
        test_mid_frame();
        test_same_cycle();
        test_empty();
        test_gaps();
        test_reset_mid_frame();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/img_region_rect_flag.md
Name: img_region_rect_flag

Overview:
- Pixel-stream stage that tags every pixel inside a programmable inclusive rectangle [left..right] x [top..bottom] with a region flag.
- Pixel data and framing pass through unchanged, one cycle later.
- Rectangle parameters are double-buffered: they change only at a frame start after an update request, so a frame never mixes old and new settings.
- Sits between image-pipeline stages; a register block drives its parameter inputs.

Parameters:
- X_BITS, 11, column coordinate width (x_t).
- Y_BITS, 10, row coordinate width (y_t).
- DATA_BITS, 24, pixel data width.
- BYPASS_SIZE, 1, 1: m_rows/m_cols registered copies of s_rows/s_cols; 0: driven to 0.
- INIT_ENABLE, 1, reset value of active enable.
- INIT_LEFT / INIT_RIGHT / INIT_TOP / INIT_BOTTOM, 0 / all-ones / 0 / all-ones, reset values of active rectangle.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- cke  in  1  clock enable for the pixel pipeline.
- update_req  in  1  pulse requesting a parameter update.
- param_enable  in  1  candidate enable.
- param_left / param_right  in  X_BITS  candidate column bounds, inclusive.
- param_top / param_bottom  in  Y_BITS  candidate row bounds, inclusive.
- update_index  out  1  toggles on each applied update.
- active_enable  out  1  currently applied enable (status).
- s_rows / s_cols  in  Y_BITS / X_BITS  frame size.
- s_row_first, s_row_last, s_col_first, s_col_last, s_de, s_valid  in  1 each  framing.
- s_data  in  DATA_BITS  pixel.
- m_rows / m_cols  out  Y_BITS / X_BITS  size out.
- m_row_first, m_row_last, m_col_first, m_col_last, m_de, m_valid  out  1 each  delayed framing.
- m_data  out  DATA_BITS  delayed pixel.
- m_region  out  1  pixel is inside the rectangle.

Behaviour:
- Reset: all m_* outputs 0; pending cleared; update_index 0; active params set to INIT_*.
- Frame start is defined as frame_start = cke & s_valid & s_row_first & s_col_first.
- Pending request:
  - Set by update_req regardless of cke.
  - Cleared when an update is applied.
  - Effective request is req_eff = pending | update_req.
- Applying an update:
  - On frame_start with req_eff=1, active params load from param_* and update_index toggles.
  - That same frame-start pixel is evaluated with the NEW params; combinational select, no bubble.
  - update_req pulses after frame start are held until the next frame start.
  - Multiple pulses in one frame produce one update.
- Coordinates, per pixel with s_valid:
  - x_cur = s_col_first ? 0 : x_reg+1.
  - y_cur = (s_row_first & s_col_first) ? 0 : (s_col_first ? y_reg+1 : y_reg).
  - x_reg/y_reg update to x_cur/y_cur when cke & s_valid.
  - Arithmetic is modulo 2^X_BITS / 2^Y_BITS.
- Region test: region = enable & (x_cur >= left) & (x_cur <= right) & (y_cur >= top) & (y_cur <= bottom).
  - Comparisons are unsigned.
  - left>right or top>bottom gives an empty region.
- Output stage:
  - Latency 1 cycle; registered when cke=1.
  - m_region = region & s_valid.
  - All other m_* are copies of s_*.
- Stall: cke=0 holds all outputs, counters and active params. update_req is still latched.
- s_valid=0: counters hold; m_valid=0 propagated; m_region=0.
- Reset mid-frame: outputs go to 0 the next cycle. The next s_row_first&s_col_first restarts coordinates.
- There is no backpressure; the upstream stage honours cke.

Decomposition:
- Package img_region_rect_pkg holds:
  - x_t and y_t typedefs.
  - rect_param_t struct {enable, left, right, top, bottom}.
  - An INIT_RECT constant.
- One sub-module, img_region_rect_param_shadow: pending flag, active-param register, update_index toggle, combinational new/old select.
- Coordinate counters and compare stay in the top module.

Test Plan:
- 8x4 frame; enable=1, left=2, right=5, top=1, bottom=2 (applied via update_req before the frame) -> m_region=1 exactly at x 2..5 of rows 1..2 (8 pixels), 1 cycle after input. update_index toggles once.
- update_req mid-frame 0 changing right=3 -> frame 0 still uses right=5. Frame 1 first pixel onward uses right=3, and its (0,0) pixel is tested with the new params.
- update_req in the same cycle as the frame-start pixel -> that frame uses the new params; pending stays 0 afterwards.
- enable=0, or left=6 right=1 -> m_region=0 for the whole frame; m_data/m_de/framing still match the input delayed by 1.
- Random cke=0 and s_valid=0 gaps inside a frame -> identical m_region pattern on the valid pixels as without gaps; outputs frozen while cke=0.
- Reset asserted at pixel (3,1) -> m_valid=0 next cycle and active params equal INIT_* (full frame, enable=1). The following frame flags all 32 pixels.
